// File: rtl/bias_pkg.sv
// Shared definitions for the bias stream unit.
// Holds the FSM state encoding, the default geometry and helpers that
// derive the bias word width and the FIFO occupancy counter width.
package bias_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } bias_state_t;

    localparam int unsigned DEF_LANES        = 32;
    localparam int unsigned DEF_LANE_WIDTH   = 9;
    localparam int unsigned DEF_ADDR_WIDTH   = 9;
    localparam int unsigned DEF_REPEAT_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    // Bias word width: all lanes packed side by side.
    function automatic int unsigned word_width(input int unsigned lanes,
                                               input int unsigned lane_width);
        return lanes * lane_width;
    endfunction

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bias_stream_unit_fifo.sv
// bias_prefetch_fifo: small synchronous prefetch FIFO.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - synchronous empty (wins over push/pop)
//   push/push_data - write one entry
//   pop        - retire the head entry
//   head_data  - current head, read straight from the storage registers
//   count      - number of valid entries (0..DEPTH)
module bias_prefetch_fifo
    import bias_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/bias_stream_unit.sv
// bias_stream_unit: per-layer bias fetch engine.
// Reads cfg_len words from a synchronous bias ROM starting at cfg_base_addr
// (address wraps), buffers them in a prefetch FIFO and emits each word
// cfg_repeat+1 times over a valid/ready stream. bias_data is zero whenever
// bias_valid is low. abort flushes everything without a done pulse.
// Ports:
//   cfg_valid/cfg_ready, cfg_base_addr, cfg_len, cfg_repeat - burst config
//   abort                     - synchronous flush
//   rom_en, rom_addr, rom_rd_data - ROM read port (data one cycle after rom_en)
//   bias_data, bias_valid, bias_ready, bias_last - output stream
//   done                      - one-cycle pulse after the last beat
module bias_stream_unit
    import bias_pkg::*;
#(
    parameter  int unsigned LANES        = DEF_LANES,
    parameter  int unsigned LANE_WIDTH   = DEF_LANE_WIDTH,
    parameter  int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter  int unsigned REPEAT_WIDTH = DEF_REPEAT_WIDTH,
    parameter  int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    localparam int unsigned W            = word_width(LANES, LANE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [ADDR_WIDTH:0]     cfg_len,
    input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
    input  logic                    abort,
    output logic                    rom_en,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [W-1:0]            rom_rd_data,
    output logic [W-1:0]            bias_data,
    output logic                    bias_valid,
    input  logic                    bias_ready,
    output logic                    bias_last,
    output logic                    done
);

    localparam int unsigned CW = count_width(FIFO_DEPTH);

    bias_state_t             state;
    logic [ADDR_WIDTH:0]     issue_left;
    logic [ADDR_WIDTH:0]     out_left;
    logic [REPEAT_WIDTH-1:0] rep_lat;
    logic [REPEAT_WIDTH-1:0] rep_cnt;
    logic                    inflight;

    logic [CW-1:0] fifo_count;
    logic [W-1:0]  fifo_head;
    logic [CW:0]   occupancy;
    logic          handshake;
    logic          rep_done;
    logic          pop;
    logic          final_word;

    // Issue decision uses registered state only, so bias_ready never reaches rom_en.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign rom_en     = (state == ST_FETCH) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign cfg_ready  = (state == ST_IDLE);

    assign bias_valid = (fifo_count != '0);
    assign bias_data  = bias_valid ? fifo_head : '0;
    assign handshake  = bias_valid && bias_ready;
    assign rep_done   = (rep_cnt == rep_lat);
    assign pop        = handshake && rep_done;
    assign final_word = (out_left == (ADDR_WIDTH+1)'(1));
    assign bias_last  = bias_valid && final_word && rep_done;

    bias_prefetch_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (inflight),
        .push_data (rom_rd_data),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            issue_left <= '0;
            out_left   <= '0;
            rep_lat    <= '0;
            rep_cnt    <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            // Clearing inflight drops the ROM word still on its way.
            state      <= ST_IDLE;
            rom_addr   <= '0;
            issue_left <= '0;
            out_left   <= '0;
            rep_cnt    <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rom_en;
            if (handshake) begin
                rep_cnt <= rep_done ? '0 : rep_cnt + REPEAT_WIDTH'(1);
            end
            if (pop) begin
                out_left <= out_left - (ADDR_WIDTH+1)'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_len != '0) begin
                            state      <= ST_FETCH;
                            rom_addr   <= cfg_base_addr;
                            issue_left <= cfg_len;
                            out_left   <= cfg_len;
                            rep_lat    <= cfg_repeat;
                            rep_cnt    <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (rom_en) begin
                        rom_addr   <= rom_addr + ADDR_WIDTH'(1);
                        issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
                        if (issue_left == (ADDR_WIDTH+1)'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && final_word) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_stream_unit.sv
module tb_bias_stream_unit;

    localparam int LANES        = 32;
    localparam int LANE_WIDTH   = 9;
    localparam int ADDR_WIDTH   = 9;
    localparam int REPEAT_WIDTH = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int W            = LANES * LANE_WIDTH;
    localparam int ASPACE       = 1 << ADDR_WIDTH;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [ADDR_WIDTH-1:0]   cfg_base_addr;
    logic [ADDR_WIDTH:0]     cfg_len;
    logic [REPEAT_WIDTH-1:0] cfg_repeat;
    logic                    abort;
    logic                    rom_en;
    logic [ADDR_WIDTH-1:0]   rom_addr;
    logic [W-1:0]            rom_rd_data = '0;
    logic [W-1:0]            bias_data;
    logic                    bias_valid;
    logic                    bias_ready;
    logic                    bias_last;
    logic                    done;

    bias_stream_unit #(
        .LANES        (LANES),
        .LANE_WIDTH   (LANE_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .REPEAT_WIDTH (REPEAT_WIDTH),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_base_addr (cfg_base_addr),
        .cfg_len       (cfg_len),
        .cfg_repeat    (cfg_repeat),
        .abort         (abort),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_rd_data   (rom_rd_data),
        .bias_data     (bias_data),
        .bias_valid    (bias_valid),
        .bias_ready    (bias_ready),
        .bias_last     (bias_last),
        .done          (done)
    );

    always #5 clk = ~clk;

    // ROM contents: lane l of word a holds (7a + 13l + 1) mod 512.
    function automatic logic [W-1:0] rom_word(input int addr);
        logic [W-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++)
            w[l*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'((addr * 7 + l * 13 + 1) % 512);
        return w;
    endfunction

    always @(posedge clk)
        if (rom_en) rom_rd_data <= rom_word(int'(rom_addr));

    typedef struct {
        logic [W-1:0] data;
        bit           last;
        bit           word_end;
    } beat_t;

    beat_t exp_q[$];
    int    addr_q[$];
    int    n_vectors     = 0;
    int    n_miscompares = 0;
    bit    model_on      = 0;
    bit    busy          = 0;
    bit    exp_done      = 0;
    int    outstanding   = 0;
    int    beats         = 0;
    int    lasts         = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one cycle, sampled at the falling edge.
    task automatic model_cycle();
        beat_t e;
        int    base, len, rep;
        if (!model_on) return;
        chk("done", W'(done), W'(exp_done));
        chk("cfg_ready", W'(cfg_ready), W'(!busy));
        exp_done = 0;
        if (rom_en) begin
            if (addr_q.size() == 0) chk("rom_en_unexpected", W'(rom_en), W'(0));
            else chk("rom_addr", W'(rom_addr), W'(addr_q.pop_front()));
            chk("buffer_bound", W'(outstanding < FIFO_DEPTH), W'(1));
        end
        if (bias_valid) begin
            if (exp_q.size() == 0) begin
                chk("bias_valid_unexpected", W'(bias_valid), W'(0));
            end else begin
                chk("bias_data", bias_data, exp_q[0].data);
                chk("bias_last", W'(bias_last), W'(exp_q[0].last));
                if (bias_ready && !abort) begin
                    e = exp_q.pop_front();
                    beats++;
                    if (e.word_end) outstanding--;
                    if (e.last) begin
                        lasts++;
                        exp_done = 1;
                        busy     = 0;
                    end
                end
            end
        end else begin
            chk("bias_data_zero", bias_data, W'(0));
            chk("bias_last_idle", W'(bias_last), W'(0));
        end
        if (rom_en) outstanding++;
        if (cfg_valid && !busy && !abort) begin
            base = int'(cfg_base_addr);
            len  = int'(cfg_len);
            rep  = int'(cfg_repeat);
            if (len == 0) exp_done = 1;
            else begin
                busy = 1;
                for (int i = 0; i < len; i++) begin
                    addr_q.push_back((base + i) % ASPACE);
                    for (int r = 0; r <= rep; r++) begin
                        e.data     = rom_word((base + i) % ASPACE);
                        e.last     = (i == len - 1) && (r == rep);
                        e.word_end = (r == rep);
                        exp_q.push_back(e);
                    end
                end
            end
        end
        if (abort) begin
            exp_q.delete();
            addr_q.delete();
            outstanding = 0;
            busy        = 0;
            exp_done    = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg(input int base, input int len, input int rep);
        cfg_valid     = 1'b1;
        cfg_base_addr = ADDR_WIDTH'(base);
        cfg_len       = (ADDR_WIDTH+1)'(len);
        cfg_repeat    = REPEAT_WIDTH'(rep);
        tick();
        cfg_valid     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk(name, W'(seen), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        int b0, l0;
        bit got;
        rst = 1'b1; cfg_valid = 1'b0; cfg_base_addr = '0; cfg_len = '0;
        cfg_repeat = '0; abort = 1'b0; bias_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", W'(cfg_ready), W'(1));
        chk("rst_rom_en", W'(rom_en), W'(0));
        chk("rst_rom_addr", W'(rom_addr), W'(0));
        chk("rst_bias_valid", W'(bias_valid), W'(0));
        chk("rst_bias_data", bias_data, W'(0));
        chk("rst_bias_last", W'(bias_last), W'(0));
        chk("rst_done", W'(done), W'(0));
        rst = 1'b0;
        model_on = 1;
        tick();

        // Basic burst: base 5, 4 words, no repeat.
        start_cfg(5, 4, 0);
        chk("t1_c1_rom_en", W'(rom_en), W'(1));
        chk("t1_c1_rom_addr", W'(rom_addr), W'(5));
        tick();
        chk("t1_c2_valid", W'(bias_valid), W'(0));
        tick();
        chk("t1_c3_valid", W'(bias_valid), W'(1));
        chk("t1_c3_lane0", W'(bias_data[8:0]), W'(36));
        chk("t1_c3_lane31", W'(bias_data[287:279]), W'(439));
        tick();
        chk("t1_c4_rom_addr", W'(rom_addr), W'(8));
        tick();
        chk("t1_c5_rom_en", W'(rom_en), W'(0));
        tick();
        chk("t1_c6_last", W'(bias_last), W'(1));
        tick();
        chk("t1_c7_done", W'(done), W'(1));
        chk("t1_c7_cfg_ready", W'(cfg_ready), W'(1));
        tick();
        chk("t1_c8_done", W'(done), W'(0));

        // Address wrap at the top of the ROM.
        start_cfg(510, 4, 0);
        chk("t2_addr0", W'(rom_addr), W'(510));
        tick();
        chk("t2_addr1", W'(rom_addr), W'(511));
        tick();
        chk("t2_addr2", W'(rom_addr), W'(0));
        tick();
        chk("t2_addr3", W'(rom_addr), W'(1));
        wait_done("t2_done_seen", 20);

        // Repeat: 3 words x 3 = 9 beats, one last.
        b0 = beats; l0 = lasts;
        start_cfg(20, 3, 2);
        wait_done("t3_done_seen", 40);
        chk("t3_beats", W'(beats - b0), W'(9));
        chk("t3_lasts", W'(lasts - l0), W'(1));

        // Output stall for 10 cycles.
        start_cfg(40, 8, 0);
        tick();
        tick();
        bias_ready = 1'b0;
        repeat (10) tick();
        chk("t4_stall_rom_en", W'(rom_en), W'(0));
        chk("t4_stall_valid", W'(bias_valid), W'(1));
        chk("t4_stall_lane0", W'(bias_data[8:0]), W'(281));
        bias_ready = 1'b1;
        wait_done("t4_done_seen", 40);

        // Irregular ready with repeats.
        got = 0;
        start_cfg(300, 6, 1);
        for (int i = 0; i < 80 && !got; i++) begin
            bias_ready = (i % 3) != 1;
            tick();
            if (done) got = 1;
        end
        chk("t5_done_seen", W'(got), W'(1));
        bias_ready = 1'b1;

        // Abort in cycle 2 of a 16-word burst.
        start_cfg(60, 16, 0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_cfg_ready", W'(cfg_ready), W'(1));
        chk("t6_valid", W'(bias_valid), W'(0));
        chk("t6_rom_en", W'(rom_en), W'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_quiet", W'(bias_valid | done | rom_en), W'(0));
        end
        // Abort beats a same-cycle config.
        abort = 1'b1;
        start_cfg(7, 3, 0);
        abort = 1'b0;
        chk("t6_prio_rom_en", W'(rom_en), W'(0));
        chk("t6_prio_cfg_ready", W'(cfg_ready), W'(1));
        tick();
        chk("t6_prio_quiet", W'(rom_en | done), W'(0));
        start_cfg(100, 2, 1);
        chk("t6_restart_addr", W'(rom_addr), W'(100));
        wait_done("t6_done_seen", 30);

        // Zero-length burst.
        start_cfg(200, 0, 0);
        chk("t7_done", W'(done), W'(1));
        chk("t7_rom_en", W'(rom_en), W'(0));
        chk("t7_cfg_ready", W'(cfg_ready), W'(1));
        tick();
        chk("t7_done_gone", W'(done), W'(0));
        chk("t7_valid", W'(bias_valid), W'(0));
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
